// File: rtl/packet_serializer.sv
// packet_serializer: captures one wide packet on a scheduler grant and emits it
// as a header transfer followed, for write packets, by BEATS data/strobe beats.
// Both output channels use a valid/ready handshake.
// Optional feature macro: SERIALIZER_STATS_EN adds pkt_count / beat_count outputs.
module packet_serializer #(
  parameter  int HEADER_SIZE = 102,
  parameter  int BEATS       = 4,
  parameter  int STRB_SIZE   = 16,
  parameter  int BEAT_SIZE   = 128,
  localparam int DATA_SIZE   = HEADER_SIZE + BEATS * (STRB_SIZE + BEAT_SIZE)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DATA_SIZE-1:0]   packet,
  input  logic                   activate,
  output logic                   consumed,
  output logic                   busy,
  output logic [HEADER_SIZE-1:0] hdr_data,
  output logic                   hdr_valid,
  input  logic                   hdr_ready,
  output logic [BEAT_SIZE-1:0]   beat_data,
  output logic [STRB_SIZE-1:0]   beat_strb,
  output logic                   beat_last,
  output logic                   beat_valid,
`ifdef SERIALIZER_STATS_EN
  output logic [31:0]            pkt_count,
  output logic [31:0]            beat_count,
`endif
  input  logic                   beat_ready
);

  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_t;

  state_t                 state_r;
  state_t                 state_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_s;
  logic [DATA_SIZE-1:0]   packet_r;
  logic                   capture_s;
  logic                   hdr_fire_s;
  logic                   beat_fire_s;

  // Unpacked views of the captured packet so the beat mux indexes by cnt_r.
  logic [BEAT_SIZE-1:0]   data_words_s [BEATS];
  logic [STRB_SIZE-1:0]   strb_words_s [BEATS];

  for (genvar k = 0; k < BEATS; k++) begin : g_unpack
    assign data_words_s[k] = packet_r[k*BEAT_SIZE +: BEAT_SIZE];
    assign strb_words_s[k] = packet_r[BEATS*BEAT_SIZE + k*STRB_SIZE +: STRB_SIZE];
  end

  // Outputs derive from registered state only; consumed is the one
  // combinational handshake back to the scheduler and is masked during reset.
  assign busy        = (state_r != IDLE);
  assign hdr_valid   = (state_r == HEADER);
  assign beat_valid  = (state_r == DATA);
  assign hdr_data    = packet_r[DATA_SIZE-1 -: HEADER_SIZE];
  assign beat_data   = data_words_s[cnt_r];
  assign beat_strb   = strb_words_s[cnt_r];
  assign beat_last   = beat_valid && (cnt_r == LAST_CNT);
  assign hdr_fire_s  = hdr_valid && hdr_ready;
  assign beat_fire_s = beat_valid && beat_ready;
  assign consumed    = capture_s && !reset;

  // Next-state, beat counter and capture decode.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (activate) begin
          capture_s = 1'b1;
          state_s   = HEADER;
        end else begin
          state_s   = IDLE;
        end
      end
      HEADER: begin
        if (hdr_fire_s) begin
          cnt_s = {CNT_W{1'b0}};
          if (packet_r[DATA_SIZE-1]) begin
            state_s = DATA;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = HEADER;
        end
      end
      DATA: begin
        if (beat_fire_s) begin
          if (cnt_r == LAST_CNT) begin
            state_s = IDLE;
            cnt_s   = {CNT_W{1'b0}};
          end else begin
            state_s = DATA;
            cnt_s   = cnt_r + CNT_W'(1);
          end
        end else begin
          state_s = DATA;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State, counter and packet capture registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      cnt_r    <= {CNT_W{1'b0}};
      packet_r <= {DATA_SIZE{1'b0}};
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      if (capture_s) begin
        packet_r <= packet;
      end
    end
  end

`ifdef SERIALIZER_STATS_EN
  // Free-running handshake counters, wrapping modulo 2^32.
  always_ff @(posedge clock) begin
    if (reset) begin
      pkt_count  <= 32'd0;
      beat_count <= 32'd0;
    end else begin
      if (hdr_fire_s) begin
        pkt_count <= pkt_count + 32'd1;
      end
      if (beat_fire_s) begin
        beat_count <= beat_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_packet_serializer.sv
// Directed self-checking bench for packet_serializer (default parameters).
module tb_packet_serializer;

  localparam int DW = 678;

  logic           clock = 1'b0;
  logic           reset;
  logic [DW-1:0]  packet;
  logic           activate;
  logic           consumed;
  logic           busy;
  logic [101:0]   hdr_data;
  logic           hdr_valid;
  logic           hdr_ready;
  logic [127:0]   beat_data;
  logic [15:0]    beat_strb;
  logic           beat_last;
  logic           beat_valid;
  logic           beat_ready;
`ifdef SERIALIZER_STATS_EN
  logic [31:0]    pkt_count;
  logic [31:0]    beat_count;
`endif

  int n_compared   = 0;
  int n_mismatched = 0;

  packet_serializer dut (
    .clock      (clock),
    .reset      (reset),
    .packet     (packet),
    .activate   (activate),
    .consumed   (consumed),
    .busy       (busy),
    .hdr_data   (hdr_data),
    .hdr_valid  (hdr_valid),
    .hdr_ready  (hdr_ready),
    .beat_data  (beat_data),
    .beat_strb  (beat_strb),
    .beat_last  (beat_last),
    .beat_valid (beat_valid),
`ifdef SERIALIZER_STATS_EN
    .pkt_count  (pkt_count),
    .beat_count (beat_count),
`endif
    .beat_ready (beat_ready)
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    n_compared++;
    if (observed !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [DW-1:0] build(
      input logic [101:0] hdr,
      input logic [127:0] d0, input logic [127:0] d1,
      input logic [127:0] d2, input logic [127:0] d3,
      input logic [15:0]  s0, input logic [15:0]  s1,
      input logic [15:0]  s2, input logic [15:0]  s3);
    return {hdr, s3, s2, s1, s0, d3, d2, d1, d0};
  endfunction

  task automatic send_pkt(input logic [DW-1:0] p);
    int n;
    activate = 1'b1;
    packet   = p;
    step();
    activate = 1'b0;
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check_value("send_done", {127'd0, busy}, 128'd0);
  endtask

  logic [DW-1:0] p;
  logic [DW-1:0] pb;
  int            pulses;
  int            n;

  initial begin
    reset      = 1'b1;
    activate   = 1'b0;
    packet     = '0;
    hdr_ready  = 1'b0;
    beat_ready = 1'b0;
    repeat (3) step();
    check_value("rst_busy",      {127'd0, busy},       128'd0);
    check_value("rst_hdr_valid", {127'd0, hdr_valid},  128'd0);
    check_value("rst_beat_valid",{127'd0, beat_valid}, 128'd0);
    check_value("rst_beat_last", {127'd0, beat_last},  128'd0);
    check_value("rst_consumed",  {127'd0, consumed},   128'd0);
    check_value("rst_hdr_data",  {26'd0, hdr_data},    128'd0);
    reset = 1'b0;
    step();

    // 1: read packet, sinks ready
    p = build({1'b0, 101'h1_2345_6789}, 128'd9, 128'd8, 128'd7, 128'd6,
              16'h1, 16'h2, 16'h3, 16'h4);
    hdr_ready  = 1'b1;
    beat_ready = 1'b1;
    activate   = 1'b1;
    packet     = p;
    #1;
    check_value("t1_consumed", {127'd0, consumed},  128'd1);
    check_value("t1_hv_t0",    {127'd0, hdr_valid}, 128'd0);
    step();
    activate = 1'b0;
    packet   = '0;
    #1;
    check_value("t1_consumed_t1", {127'd0, consumed},   128'd0);
    check_value("t1_hv_t1",       {127'd0, hdr_valid},  128'd1);
    check_value("t1_hdr_data",    {26'd0, hdr_data},    {26'd0, 1'b0, 101'h1_2345_6789});
    check_value("t1_bv_t1",       {127'd0, beat_valid}, 128'd0);
    check_value("t1_busy_t1",     {127'd0, busy},       128'd1);
    step();
    #1;
    check_value("t1_hv_t2",   {127'd0, hdr_valid},  128'd0);
    check_value("t1_busy_t2", {127'd0, busy},       128'd0);
    check_value("t1_bv_t2",   {127'd0, beat_valid}, 128'd0);

    // 2: write packet, data k = k+1, sinks ready
    p = build({1'b1, 101'h5A5A}, 128'd1, 128'd2, 128'd3, 128'd4,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    activate = 1'b1;
    packet   = p;
    #1;
    check_value("t2_consumed", {127'd0, consumed}, 128'd1);
    step();
    activate = 1'b0;
    #1;
    check_value("t2_hv",       {127'd0, hdr_valid}, 128'd1);
    check_value("t2_hdr_data", {26'd0, hdr_data},   {26'd0, 1'b1, 101'h5A5A});
    step();
    for (int k = 0; k < 4; k++) begin
      #1;
      check_value("t2_bv",   {127'd0, beat_valid}, 128'd1);
      check_value("t2_data", beat_data,            128'(k + 1));
      check_value("t2_strb", {112'd0, beat_strb},  {112'd0, 16'hFFFF});
      check_value("t2_last", {127'd0, beat_last},  {127'd0, (k == 3)});
      check_value("t2_hv0",  {127'd0, hdr_valid},  128'd0);
      step();
    end
    #1;
    check_value("t2_busy_end", {127'd0, busy},       128'd0);
    check_value("t2_bv_end",   {127'd0, beat_valid}, 128'd0);

    // 3: header stall then beat 2 held off for 5 cycles
    p = build({1'b1, 101'h3}, 128'd1, 128'd2, 128'd3, 128'd4,
              16'h1111, 16'h2222, 16'h3333, 16'h4444);
    hdr_ready = 1'b0;
    activate  = 1'b1;
    packet    = p;
    #1;
    check_value("t3_consumed", {127'd0, consumed}, 128'd1);
    step();
    activate = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      check_value("t3_hv_stall",  {127'd0, hdr_valid}, 128'd1);
      check_value("t3_hdr_stall", {26'd0, hdr_data},   {26'd0, 1'b1, 101'h3});
      check_value("t3_bv_stall",  {127'd0, beat_valid}, 128'd0);
      step();
    end
    hdr_ready = 1'b1;
    #1;
    check_value("t3_hv_go", {127'd0, hdr_valid}, 128'd1);
    step();
    for (int k = 0; k < 2; k++) begin
      #1;
      check_value("t3_data_pre", beat_data, 128'(k + 1));
      step();
    end
    beat_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_value("t3_bv_hold",   {127'd0, beat_valid}, 128'd1);
      check_value("t3_data_hold", beat_data,            128'd3);
      check_value("t3_strb_hold", {112'd0, beat_strb},  {112'd0, 16'h3333});
      check_value("t3_last_hold", {127'd0, beat_last},  128'd0);
      step();
    end
    beat_ready = 1'b1;
    #1;
    check_value("t3_data_b2", beat_data, 128'd3);
    step();
    #1;
    check_value("t3_data_b3", beat_data,           128'd4);
    check_value("t3_strb_b3", {112'd0, beat_strb}, {112'd0, 16'h4444});
    check_value("t3_last_b3", {127'd0, beat_last}, 128'd1);
    step();
    #1;
    check_value("t3_busy_end", {127'd0, busy}, 128'd0);

    // 4: activate held high for 10 cycles across a write
    p  = build({1'b1, 101'hA}, 128'd10, 128'd11, 128'd12, 128'd13,
               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    pb = build({1'b1, 101'hB}, 128'd20, 128'd21, 128'd22, 128'd23,
               16'h00FF, 16'h00FF, 16'h00FF, 16'h00FF);
    pulses   = 0;
    activate = 1'b1;
    packet   = p;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (consumed) pulses++;
      check_value("t4_consumed", {127'd0, consumed}, {127'd0, (c == 0 || c == 6)});
      if (c == 7) begin
        check_value("t4_hdr_b", {26'd0, hdr_data},  {26'd0, 1'b1, 101'hB});
        check_value("t4_hv_b",  {127'd0, hdr_valid}, 128'd1);
      end
      if (c == 8) begin
        check_value("t4_data_b", beat_data, 128'd20);
      end
      step();
      packet = pb;
    end
    activate = 1'b0;
    check_value("t4_pulses", 128'(pulses), 128'd2);
    n = 0;
    while (busy && n < 20) begin
      step();
      n++;
    end
    check_value("t4_drain", {127'd0, busy}, 128'd0);

    // 5: reset in DATA at cnt=1, then a fresh read
    p = build({1'b1, 101'h55}, 128'd1, 128'd2, 128'd3, 128'd4,
              16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    activate = 1'b1;
    packet   = p;
    step();
    activate = 1'b0;
    step();
    step();
    #1;
    check_value("t5_bv_cnt1",   {127'd0, beat_valid}, 128'd1);
    check_value("t5_data_cnt1", beat_data,            128'd2);
    reset = 1'b1;
    step();
    #1;
    check_value("t5_hv_rst",   {127'd0, hdr_valid},  128'd0);
    check_value("t5_bv_rst",   {127'd0, beat_valid}, 128'd0);
    check_value("t5_busy_rst", {127'd0, busy},       128'd0);
    check_value("t5_last_rst", {127'd0, beat_last},  128'd0);
    check_value("t5_cons_rst", {127'd0, consumed},   128'd0);
    reset = 1'b0;
    step();
    p = build({1'b0, 101'h77}, 128'd0, 128'd0, 128'd0, 128'd0,
              16'h0, 16'h0, 16'h0, 16'h0);
    activate = 1'b1;
    packet   = p;
    #1;
    check_value("t5_consumed", {127'd0, consumed}, 128'd1);
    step();
    activate = 1'b0;
    #1;
    check_value("t5_hv",       {127'd0, hdr_valid}, 128'd1);
    check_value("t5_hdr_data", {26'd0, hdr_data},   {26'd0, 1'b0, 101'h77});
    step();
    #1;
    check_value("t5_busy_end", {127'd0, busy}, 128'd0);

`ifdef SERIALIZER_STATS_EN
    // 6: statistics counters after 3 writes and 2 reads
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    check_value("t6_pkt_rst",  128'(pkt_count),  128'd0);
    check_value("t6_beat_rst", 128'(beat_count), 128'd0);
    for (int i = 0; i < 5; i++) begin
      p = build({(i < 3), 101'(i)}, 128'd1, 128'd2, 128'd3, 128'd4,
                16'hF, 16'hF, 16'hF, 16'hF);
      send_pkt(p);
    end
    check_value("t6_pkt_count",  128'(pkt_count),  128'd5);
    check_value("t6_beat_count", 128'(beat_count), 128'd12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
